// File: rtl/ram_mode_arbiter.sv
// Arbitrates the shared ibuf/wbuf/bbuf/obuf RAM set between the 16-bit and 8-bit paths.
// Optional statistics counters: define RAM_MODE_ARBITER_STATS_EN.
module ram_mode_arbiter #(
  parameter int DRAIN_CYCLES = 2,
  parameter int MAX_HOLD     = 1024,
  parameter int INFLIGHT_W   = 6,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_16,
  input  logic             req_8,
  input  logic             rd_issue,
  input  logic             rd_valid,
  output logic             gnt_16,
  output logic             gnt_8,
  output logic             yield_16,
  output logic             yield_8,
  output logic             choose_mux,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] switch_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    SWITCH,
    GRANT,
    DRAIN
  } state_t;

  localparam int HW =
    (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam int DW =
    (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

  localparam logic [HW-1:0] HMAX = HW'(MAX_HOLD);
  localparam logic [DW-1:0] DLAST = DW'(DRAIN_CYCLES);
  localparam logic [INFLIGHT_W-1:0] IMAX = '1;

  state_t r_state;
  state_t w_next;

  logic r_own_16;
  logic r_rr_16;
  logic r_choose;
  logic r_gnt_16;
  logic r_gnt_8;
  logic r_yield_16;
  logic r_yield_8;
  logic r_err;

  logic [INFLIGHT_W-1:0] r_infl;
  logic [HW-1:0]         r_hold;
  logic [DW-1:0]         r_drain;

  logic [INFLIGHT_W-1:0] w_infl_nxt;
  logic [HW-1:0]         w_hold_nxt;
  logic [DW-1:0]         w_drain_nxt;

  logic w_any_req;
  logic w_win_16;
  logic w_own_nxt;
  logic w_own_req;
  logic w_other_req;
  logic w_infl_zero;
  logic w_drain_done;
  logic w_sw_enter;
  logic w_ovf;
  logic w_unf;
  logic w_err_set;

  assign w_any_req   = req_16 | req_8;
  assign w_win_16    = req_16 & (~req_8 | r_rr_16);
  assign w_own_req   = r_own_16 ? req_16 : req_8;
  assign w_other_req = r_own_16 ? req_8 : req_16;

  always_comb begin
    w_infl_nxt = r_infl;
    w_ovf      = 1'b0;
    case ({rd_issue, rd_valid})
      2'b10: begin
        if (r_infl == IMAX) w_ovf = 1'b1;
        else w_infl_nxt = r_infl + INFLIGHT_W'(1);
      end
      2'b01: begin
        if (r_infl != '0)
          w_infl_nxt = r_infl - INFLIGHT_W'(1);
      end
      default: ;
    endcase
  end

  assign w_unf = rd_valid & (r_infl == '0);
  assign w_err_set = w_unf | w_ovf |
    (rd_issue & ~r_gnt_16 & ~r_gnt_8);

  // Drain timing keys off the post-update count so that
  // a zero-length drain leaves on the last rd_valid edge.
  assign w_infl_zero  = (w_infl_nxt == '0);
  assign w_drain_done = (r_drain == DLAST);

  always_comb begin
    w_next      = r_state;
    w_own_nxt   = r_own_16;
    w_hold_nxt  = r_hold;
    w_drain_nxt = r_drain;
    case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_own_nxt = w_win_16;
          w_next = (w_win_16 == r_choose) ? GRANT : SWITCH;
        end
      end
      SWITCH: w_next = GRANT;
      GRANT: begin
        if (!w_own_req)
          w_next = DRAIN;
        else if (w_other_req && r_hold != HMAX)
          w_hold_nxt = r_hold + HW'(1);
      end
      DRAIN: begin
        if (!w_infl_zero) begin
          w_drain_nxt = '0;
        end else if (w_drain_done) begin
          w_drain_nxt = '0;
          w_next = IDLE;
        end else begin
          w_drain_nxt = r_drain + DW'(1);
        end
      end
      default: w_next = IDLE;
    endcase
    if (w_next == GRANT && r_state != GRANT)
      w_hold_nxt = '0;
  end

  assign w_sw_enter = (w_next == SWITCH) &&
                      (r_state != SWITCH);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_own_16   <= 1'b1;
      r_rr_16    <= 1'b1;
      r_choose   <= 1'b1;
      r_gnt_16   <= 1'b0;
      r_gnt_8    <= 1'b0;
      r_yield_16 <= 1'b0;
      r_yield_8  <= 1'b0;
      r_err      <= 1'b0;
      r_infl     <= '0;
      r_hold     <= '0;
      r_drain    <= '0;
    end else begin
      r_state  <= w_next;
      r_own_16 <= w_own_nxt;
      if (r_state == IDLE && w_any_req)
        r_rr_16 <= ~w_win_16;
      if (w_sw_enter)
        r_choose <= ~r_choose;
      r_gnt_16 <= (w_next == GRANT) & w_own_nxt;
      r_gnt_8  <= (w_next == GRANT) & ~w_own_nxt;
      r_yield_16 <= (w_next == GRANT) & w_own_nxt &
                    (w_hold_nxt == HMAX);
      r_yield_8  <= (w_next == GRANT) & ~w_own_nxt &
                    (w_hold_nxt == HMAX);
      if (w_err_set)
        r_err <= 1'b1;
      r_infl  <= w_infl_nxt;
      r_hold  <= w_hold_nxt;
      r_drain <= w_drain_nxt;
    end
  end

  assign gnt_16     = r_gnt_16;
  assign gnt_8      = r_gnt_8;
  assign yield_16   = r_yield_16;
  assign yield_8    = r_yield_8;
  assign choose_mux = r_choose;
  assign busy       = (r_state != IDLE);
  assign err        = r_err;

`ifdef RAM_MODE_ARBITER_STATS_EN
  logic [CNT_W-1:0] r_sw_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_stall;

  assign w_stall = (req_16 & ~r_gnt_16) |
                   (req_8 & ~r_gnt_8);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sw_cnt    <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_sw_enter)
        r_sw_cnt <= r_sw_cnt + CNT_W'(1);
      if (w_stall)
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign switch_cnt = r_sw_cnt;
  assign stall_cnt  = r_stall_cnt;
`else
  assign switch_cnt = '0;
  assign stall_cnt  = '0;
`endif

endmodule

// File: tb/tb_ram_mode_arbiter.sv
// Directed bench for ram_mode_arbiter.
// Expected counter values follow RAM_MODE_ARBITER_STATS_EN.
module tb_ram_mode_arbiter;

`ifdef RAM_MODE_ARBITER_STATS_EN
  localparam int ST = 1;
`else
  localparam int ST = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req_16 = 1'b0;
  logic       req_8 = 1'b0;
  logic       rd_issue = 1'b0;
  logic       rd_valid = 1'b0;
  logic       gnt_16;
  logic       gnt_8;
  logic       yield_16;
  logic       yield_8;
  logic       choose_mux;
  logic       busy;
  logic       err;
  logic [7:0] switch_cnt;
  logic [7:0] stall_cnt;

  int n_chk = 0;
  int n_fail = 0;

  ram_mode_arbiter #(
    .DRAIN_CYCLES(2),
    .MAX_HOLD(4),
    .INFLIGHT_W(2),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_16(req_16),
    .req_8(req_8),
    .rd_issue(rd_issue),
    .rd_valid(rd_valid),
    .gnt_16(gnt_16),
    .gnt_8(gnt_8),
    .yield_16(yield_16),
    .yield_8(yield_8),
    .choose_mux(choose_mux),
    .busy(busy),
    .err(err),
    .switch_cnt(switch_cnt),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    req_16 = 0;
    req_8 = 0;
    rd_issue = 0;
    rd_valid = 0;
    reset = 0;
    step(2);
    reset = 1;
  endtask

  initial begin
    step(2);
    check("rst_gnt16", 32'(gnt_16), 0);
    check("rst_gnt8", 32'(gnt_8), 0);
    check("rst_mux", 32'(choose_mux), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_err", 32'(err), 0);
    check("rst_yield", 32'({yield_16, yield_8}), 0);
    check("rst_swcnt", 32'(switch_cnt), 0);
    reset = 1;

    // 16-bit path, mux already selected
    req_16 = 1;
    step();
    check("t1_gnt16", 32'(gnt_16), 1);
    check("t1_gnt8", 32'(gnt_8), 0);
    check("t1_mux", 32'(choose_mux), 1);
    check("t1_busy", 32'(busy), 1);
    check("t1_swcnt", 32'(switch_cnt), 0);
    check("t1_stall", 32'(stall_cnt), 32'(ST));
    req_16 = 0;
    step(3);
    check("t1_drain_gnt", 32'(gnt_16), 0);
    check("t1_drain_busy", 32'(busy), 1);
    step();
    check("t1_idle", 32'(busy), 0);

    // 8-bit path from reset needs a switch
    do_reset();
    req_8 = 1;
    step();
    check("t2_sw_mux", 32'(choose_mux), 0);
    check("t2_sw_gnt8", 32'(gnt_8), 0);
    check("t2_sw_busy", 32'(busy), 1);
    check("t2_swcnt", 32'(switch_cnt), 32'(ST));
    step();
    check("t2_gnt8", 32'(gnt_8), 1);
    check("t2_gnt16", 32'(gnt_16), 0);
    check("t2_stall", 32'(stall_cnt), 32'(2 * ST));

    // three reads, release, staggered returns
    rd_issue = 1;
    step(3);
    rd_issue = 0;
    req_8 = 0;
    step();
    check("t3_drop_gnt", 32'(gnt_8), 0);
    check("t3_drop_busy", 32'(busy), 1);
    for (int i = 0; i < 5; i++) begin
      rd_valid = (i % 2 == 0);
      step();
      check("t3_wait_busy", 32'(busy), 1);
      check("t3_wait_mux", 32'(choose_mux), 0);
    end
    rd_valid = 0;
    step();
    check("t3_d2_busy", 32'(busy), 1);
    step();
    check("t3_idle", 32'(busy), 0);
    check("t3_mux", 32'(choose_mux), 0);
    check("t3_err", 32'(err), 0);
    check("t3_swcnt", 32'(switch_cnt), 32'(ST));

    // simultaneous requests alternate
    do_reset();
    req_16 = 1;
    req_8 = 1;
    step();
    check("t4_a_gnt16", 32'(gnt_16), 1);
    check("t4_a_gnt8", 32'(gnt_8), 0);
    req_16 = 0;
    req_8 = 0;
    step(4);
    check("t4_a_idle", 32'(busy), 0);
    req_16 = 1;
    req_8 = 1;
    step();
    check("t4_b_sw_mux", 32'(choose_mux), 0);
    check("t4_b_sw_gnt", 32'({gnt_16, gnt_8}), 0);
    step();
    check("t4_b_gnt8", 32'(gnt_8), 1);
    check("t4_b_gnt16", 32'(gnt_16), 0);
    req_16 = 0;
    req_8 = 0;
    step(4);
    check("t4_b_idle", 32'(busy), 0);

    // hold limit raises yield
    do_reset();
    req_16 = 1;
    req_8 = 1;
    step();
    check("t5_gnt16", 32'(gnt_16), 1);
    check("t5_y0", 32'(yield_16), 0);
    step(3);
    check("t5_y3", 32'(yield_16), 0);
    step();
    check("t5_y4", 32'(yield_16), 1);
    check("t5_y8", 32'(yield_8), 0);
    step();
    check("t5_y_keep", 32'(yield_16), 1);
    req_16 = 0;
    step();
    check("t5_rel_gnt", 32'(gnt_16), 0);
    check("t5_rel_y", 32'(yield_16), 0);
    step(3);
    check("t5_idle", 32'(busy), 0);
    check("t5_idle_mux", 32'(choose_mux), 1);
    check("t5_idle_gnt8", 32'(gnt_8), 0);
    step();
    check("t5_sw_mux", 32'(choose_mux), 0);
    check("t5_sw_gnt8", 32'(gnt_8), 0);
    step();
    check("t5_gnt8", 32'(gnt_8), 1);
    check("t5_y8_new", 32'(yield_8), 0);
    req_8 = 0;

    // spurious rd_valid, then async reset mid-grant
    do_reset();
    rd_valid = 1;
    step();
    check("t6_err", 32'(err), 1);
    rd_valid = 0;
    step();
    check("t6_err_keep", 32'(err), 1);
    req_8 = 1;
    step(2);
    check("t6_gnt8", 32'(gnt_8), 1);
    #2 reset = 0;
    #1;
    check("t6_ar_gnt8", 32'(gnt_8), 0);
    check("t6_ar_mux", 32'(choose_mux), 1);
    check("t6_ar_err", 32'(err), 0);
    check("t6_ar_busy", 32'(busy), 0);
    req_8 = 0;
    step();
    reset = 1;

    // counter overflow
    do_reset();
    req_16 = 1;
    step();
    rd_issue = 1;
    step(3);
    check("t7_full_err", 32'(err), 0);
    step();
    check("t7_ovf_err", 32'(err), 1);
    rd_issue = 0;
    req_16 = 0;

    // read issued with nobody granted
    do_reset();
    rd_issue = 1;
    step();
    check("t8_nognt_err", 32'(err), 1);
    rd_issue = 0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d",
             n_chk, n_fail);
    $finish;
  end

endmodule
